// File: rtl/alu_2.sv
// alu_2 -- registered arithmetic/logic unit.
//
// Computes Y = f(A, B, sel) plus carry/zero/negative/overflow and presents the
// result one clock after the request is accepted. Nothing passes from the
// inputs to the outputs without going through a register.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high, has priority over in_valid
//   in_valid  qualifies A, B, sel this cycle
//   A, B      operands (WIDTH bits, unsigned; two's complement for overflow)
//   sel       operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR
//   Y         registered result
//   out_valid one-cycle pulse when Y and the flags are updated
//   carry     ADD carry out / SUB no-borrow / shifted-out bit, else 0
//   zero      Y == 0
//   negative  Y[WIDTH-1]
//   overflow  signed overflow for ADD/SUB, else 0
module alu_2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   localparam int STAGES = 1;
   localparam int MSB    = WIDTH - 1;

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
   } rsp_t;

   localparam rsp_t RSP_RST = '{y: '0, c: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0};

   logic [STAGES:0] vld_pipe;
   logic [WIDTH:0]  sum;
   logic [WIDTH:0]  dif;
   rsp_t            rsp_d;
   rsp_t            rsp_q;

   // One extra bit on each side so the carry/borrow falls out of bit WIDTH.
   assign sum = {1'b0, A} + {1'b0, B};
   assign dif = {1'b0, A} - {1'b0, B};

   always_comb begin
      rsp_d = '0;
      case (sel)
         3'b000: begin
            rsp_d.y = sum[MSB:0];
            rsp_d.c = sum[WIDTH];
            rsp_d.v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         3'b001: begin
            rsp_d.y = dif[MSB:0];
            // Bit WIDTH of the extended difference is the borrow; carry is its inverse.
            rsp_d.c = ~dif[WIDTH];
            rsp_d.v = (A[MSB] != B[MSB]) && (dif[MSB] != A[MSB]);
         end
         3'b010: rsp_d.y = A & B;
         3'b011: rsp_d.y = A | B;
         3'b100: rsp_d.y = A ^ B;
         3'b101: rsp_d.y = ~A;
         3'b110: begin
            rsp_d.y = {A[MSB-1:0], 1'b0};
            rsp_d.c = A[MSB];
         end
         default: begin
            rsp_d.y = {1'b0, A[MSB:1]};
            rsp_d.c = A[0];
         end
      endcase
      rsp_d.z = (rsp_d.y == '0);
      rsp_d.n = rsp_d.y[MSB];
   end

   // Stage 0 of the valid pipe is the live request.
   assign vld_pipe[0] = in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe[STAGES:1] <= '0;
         rsp_q              <= RSP_RST;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         // Idle cycles keep the previous result and flags.
         if (in_valid) rsp_q <= rsp_d;
      end
   end

   assign Y         = rsp_q.y;
   assign carry     = rsp_q.c;
   assign zero      = rsp_q.z;
   assign negative  = rsp_q.n;
   assign overflow  = rsp_q.v;
   assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_alu_2.sv
// Bench for alu_2: a reference model pushes expected results into a queue as
// each request is driven; they are popped and compared when out_valid rises.
module tb_alu_2;

   typedef struct packed {
      logic [3:0] y;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [2:0] sel = '0;
   logic [3:0] Y;
   logic       out_valid, carry, zero, negative, overflow;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   exp_t last;
   int   sweep_y[8] = '{7, 1, 0, 7, 7, 11, 8, 2};

   alu_2 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .sel(sel),
      .Y(Y), .out_valid(out_valid), .carry(carry), .zero(zero),
      .negative(negative), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Integer-domain model: signed overflow from range checks on the true result.
   function automatic exp_t model(input int a, input int b, input int s);
      exp_t e;
      int   r, sa, sb, sr;
      e  = '0;
      r  = 0;
      sr = 0;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      case (s)
         0: begin r = a + b; e.c = (r > 15); sr = sa + sb; e.v = (sr > 7 || sr < -8); end
         1: begin r = a - b; e.c = (a >= b); sr = sa - sb; e.v = (sr > 7 || sr < -8); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 15 - a;
         6: begin r = a * 2; e.c = (a >= 8); end
         default: begin r = a / 2; e.c = (a % 2 == 1); end
      endcase
      e.y = 4'(r & 15);
      e.z = (e.y == 4'd0);
      e.n = e.y[3];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, "_y"}, 32'(Y), 32'(e.y));
      chk({tag, "_carry"}, 32'(carry), 32'(e.c));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
      chk({tag, "_neg"}, 32'(negative), 32'(e.n));
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.v));
   endtask

   // One clock: drive at negedge, push expectation, sample 1 ns after posedge.
   task automatic cyc(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] s, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; A = a; B = b; sel = s;
      if (!r && v) q.push_back(model(int'(a), int'(b), int'(s)));
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         last = '{y: 4'd0, c: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0};
         chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
         chk_all(tag, last);
      end else if (out_valid) begin
         if (q.size() == 0) begin
            chk({tag, "_unexpected_valid"}, 32'(out_valid), 32'd0);
         end else begin
            e = q.pop_front();
            last = e;
            chk_all(tag, e);
         end
      end else begin
         chk({tag, "_ovalid"}, 32'(out_valid), 32'(v));
         if (v && q.size() > 0) void'(q.pop_front());
         chk_all({tag, "_hold"}, last);
      end
   endtask

   initial begin
      // Reset held two cycles with in_valid high: request must be discarded.
      cyc(1, 1, 4'd4, 4'd3, 3'd0, "rst0");
      cyc(1, 1, 4'd4, 4'd3, 3'd0, "rst1");

      // Op sweep, also against the literal expected Y values.
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 4'd4, 4'd3, 3'(i), "sweep");
         chk("sweep_y_const", 32'(Y), 32'(sweep_y[i]));
      end

      // ADD wrap and signed overflow.
      cyc(0, 1, 4'd15, 4'd1, 3'd0, "add_wrap");
      chk("add_wrap_zero_const", 32'(zero), 32'd1);
      cyc(0, 1, 4'd7, 4'd1, 3'd0, "add_ovf");
      chk("add_ovf_const", 32'({Y, overflow, negative, carry}), 32'({4'd8, 3'b110}));

      // SUB borrow and signed overflow.
      cyc(0, 1, 4'd3, 4'd4, 3'd1, "sub_borrow");
      chk("sub_borrow_const", 32'({Y, carry, negative, overflow}), 32'({4'd15, 3'b010}));
      cyc(0, 1, 4'd8, 4'd1, 3'd1, "sub_ovf");
      chk("sub_ovf_const", 32'({Y, overflow, carry}), 32'({4'd7, 2'b11}));

      // Hold: idle cycles with changing inputs must not disturb the result.
      cyc(0, 1, 4'd4, 4'd3, 3'd0, "hold_req");
      cyc(0, 0, 4'd9, 4'd2, 3'd6, "hold1");
      cyc(0, 0, 4'd1, 4'd14, 3'd5, "hold2");
      cyc(0, 0, 4'd12, 4'd5, 3'd1, "hold3");
      chk("hold_y_const", 32'(Y), 32'd7);

      // Reset on the same edge as a valid ADD: result discarded.
      cyc(0, 1, 4'd2, 4'd2, 3'd0, "pre_rst");
      cyc(1, 1, 4'd15, 4'd1, 3'd0, "mid_rst");
      cyc(0, 1, 4'd5, 4'd6, 3'd4, "post_rst");

      // Random mix of valid and idle cycles.
      for (int i = 0; i < 60; i++)
         cyc(0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 3'($urandom), "rand");

      cyc(0, 0, 4'd0, 4'd0, 3'd0, "drain");
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_2.md
Name: alu_2

Overview:
- 4-bit (parameterizable) registered arithmetic/logic unit.
- Takes two operands A, B and a 3-bit operation select `sel`.
- Produces a result Y plus status flags, registered one clock after the request is accepted.
- Used as the general-purpose datapath ALU; output is a registered copy of the combinational result.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies A, B, sel this cycle
- A  input  WIDTH  operand A (unsigned; two's complement for overflow flag)
- B  input  WIDTH  operand B
- sel  input  3  operation select
- Y  output  WIDTH  registered result
- out_valid  output  1  high for one cycle when Y and flags are updated
- carry  output  1  carry out (ADD) / no-borrow (SUB) / shifted-out bit (shifts), else 0
- zero  output  1  Y == 0
- negative  output  1  Y[WIDTH-1]
- overflow  output  1  signed overflow for ADD/SUB, else 0

Behaviour:
- All state updates on rising clk edge; no combinational path from inputs to outputs.
- Reset (rst=1 at clock edge): Y=0, out_valid=0, carry=0, zero=1, negative=0, overflow=0. rst has priority over in_valid.
- Latency: 1 cycle. If in_valid=1 at edge N, then after edge N:
  - Y and flags hold the result for that operation.
  - out_valid=1 for exactly that cycle.
- If in_valid=0 at an edge: out_valid=0; Y and flags hold their previous values.
- Back-to-back requests accepted every cycle; no backpressure.
- Operation encoding (all results truncated to WIDTH bits):
  - 000 ADD: Y=A+B; carry=bit WIDTH of the (WIDTH+1)-bit sum; overflow=(A[msb]==B[msb]) && (Y[msb]!=A[msb]).
  - 001 SUB: Y=A-B (modulo 2^WIDTH); carry=1 when A>=B unsigned (no borrow); overflow=(A[msb]!=B[msb]) && (Y[msb]!=A[msb]).
  - 010 AND: Y=A&B.
  - 011 OR: Y=A|B.
  - 100 XOR: Y=A^B.
  - 101 NOT: Y=~A (B ignored).
  - 110 SHL: Y=A<<1, LSB filled with 0; carry=A[msb].
  - 111 SHR: Y=A>>1 logical, MSB filled with 0; carry=A[0].
- Logic ops (010–101): carry=0, overflow=0.
- Shifts: overflow=0.
- zero and negative are derived from the new Y for every operation.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH with no saturation.
- Undefined/X sel is not guarded; all 8 codes are defined.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> Y=0, zero=1, out_valid=0, other flags 0. Deassert -> next valid request is processed normally.
- Op sweep: A=4, B=3, sel 000..111, one per cycle with in_valid=1. Required Y one cycle later, in order: 7, 1, 0, 7, 7, 11, 8, 2. zero=1 only for AND. carry=1 for SUB only. negative=1 for NOT and SHL.
- ADD wrap: A=15, B=1, sel=000 -> Y=0, carry=1, zero=1, overflow=0. A=7, B=1 -> Y=8, overflow=1, negative=1, carry=0.
- SUB borrow: A=3, B=4, sel=001 -> Y=15, carry=0, negative=1, overflow=0. A=8, B=1 -> Y=7, overflow=1, carry=1.
- Hold: issue A=4, B=3 ADD, then in_valid=0 for 3 cycles with changing A/B/sel -> Y stays 7, out_valid low after the first cycle.
- Reset mid-stream: in_valid=1 with ADD and rst=1 on the same edge -> outputs at reset values, out_valid=0, result discarded.
